// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU control codes, flag bit
// positions and default widths. Imported by the interface, the arbiter core
// and the top.
package alu_ctrl_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ALUC_W_DEF = 5;

    // Bit 4 of an ALU control code requests an NZCV update.
    localparam int SETFLAGS_BIT = 4;

    // Flag positions inside alu_flags / cpsr.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [4:0] {
        ALU_AND  = 5'b00000,
        ALU_OR   = 5'b00001,
        ALU_ADD  = 5'b00010,
        ALU_ADDS = 5'b10010,
        ALU_SUB  = 5'b00110,
        ALU_SUBS = 5'b10110,
        ALU_PASS = 5'b00111
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters (plus the response
// consumer) and the arbiter.
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_a/req_b/req_aluc: payloads, requester i in slice [i*W +: W]
//   rsp_*               : single registered response slot with backpressure
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ALUC_W = ALUC_W_DEF
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [2*ALUC_W-1:0] req_aluc;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_zero;
    logic                rsp_flags_wr;

    modport master (
        output req_valid, req_a, req_b, req_aluc, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_flags_wr
    );

    modport slave (
        input  req_valid, req_a, req_b, req_aluc, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_flags_wr
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way arbiter with a round-robin pointer.
//   clk, reset  : clock, synchronous active-high reset
//   req         : per-requester valid
//   advance     : the current grant was accepted this cycle
//   grant       : index of the winning requester (combinational)
//   grant_valid : at least one requester is valid
// With FIXED_PRIO=1 requester 0 always wins a tie and the pointer is frozen.
module rr_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant,
    output logic       grant_valid
);

    // Index of the requester preferred on a tie.
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (advance && !FIXED_PRIO) begin
            rr_ptr <= ~grant;
        end
    end

    always_comb begin
        grant_valid = |req;
        grant       = 1'b0;
        case (req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = FIXED_PRIO ? 1'b0 : rr_ptr;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (requester 0) and the
// address/auxiliary unit (requester 1). The winner's payload drives the ALU
// combinationally; the ALU outputs are captured into a one-entry response
// slot. Also owns the architectural NZCV register.
//   clk, reset        : clock, synchronous active-high reset
//   bus               : request/response bundle (slave side)
//   alu_a/b/c         : operands and control code to the ALU
//   alu_result/zero/flags/write_flags : ALU outputs
//   cpsr_wr_en/data   : external NZCV restore
//   cpsr              : NZCV, [3]=Z [2]=N [1]=C [0]=V
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ALUC_W     = ALUC_W_DEF,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [ALUC_W-1:0] alu_c,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [3:0]        alu_flags,
    input  logic              alu_write_flags,
    input  logic              cpsr_wr_en,
    input  logic [3:0]        cpsr_wr_data,
    output logic [3:0]        cpsr
);

    logic              grant;
    logic              grant_valid;
    logic              slot_free;
    logic              accept;

    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic              rsp_flags_wr_q;
    logic [3:0]        cpsr_q;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.req_valid),
        .advance     (accept),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // The slot can take a new result if it is empty or being drained now.
    assign slot_free = !rsp_valid_q || bus.rsp_ready;

    // grant_valid already implies the granted requester is valid. Reset
    // masks readiness so nothing looks accepted while the block is held.
    assign accept        = grant_valid && slot_free && !reset;
    assign bus.req_ready = {accept && grant, accept && !grant};

    // The ALU sees the winner even while the slot is stalled; an idle cycle
    // drives a harmless AND of zeros that does not touch the flags.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_c = ALUC_W'(ALU_AND);
        if (grant_valid) begin
            if (grant) begin
                alu_a = bus.req_a[2*DATA_W-1:DATA_W];
                alu_b = bus.req_b[2*DATA_W-1:DATA_W];
                alu_c = bus.req_aluc[2*ALUC_W-1:ALUC_W];
            end else begin
                alu_a = bus.req_a[DATA_W-1:0];
                alu_b = bus.req_b[DATA_W-1:0];
                alu_c = bus.req_aluc[ALUC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_flags_wr_q <= 1'b0;
            cpsr_q         <= 4'b0000;
        end else begin
            if (accept) begin
                rsp_valid_q    <= 1'b1;
                rsp_id_q       <= grant;
                rsp_result_q   <= alu_result;
                rsp_zero_q     <= alu_zero;
                rsp_flags_wr_q <= alu_write_flags;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            // A flag-setting ALU op shadows a simultaneous external restore.
            if (accept && alu_write_flags) begin
                cpsr_q <= alu_flags;
            end else if (cpsr_wr_en) begin
                cpsr_q <= cpsr_wr_data;
            end
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_flags_wr = rsp_flags_wr_q;
    assign cpsr             = cpsr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    localparam int DW = 64;
    localparam int CW = 5;

    typedef struct packed {
        logic [63:0] result;
        logic        zero;
        logic [3:0]  flags;
        logic        wf;
    } alu_out_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(DW), .ALUC_W(CW)) bus ();
    alu_arbiter_if #(.DATA_W(DW), .ALUC_W(CW)) bus_fp ();

    logic [63:0] alu_a, alu_b, fp_alu_a, fp_alu_b;
    logic [4:0]  alu_c, fp_alu_c;
    alu_out_t    alu_o, fp_alu_o;
    logic        cpsr_wr_en;
    logic [3:0]  cpsr_wr_data;
    logic [3:0]  cpsr, fp_cpsr;

    // Behavioural ALU: plain arithmetic on 65-bit sums for carry/overflow.
    function automatic alu_out_t alu_fn(input logic [63:0] a, input logic [63:0] b,
                                        input logic [4:0] c);
        alu_out_t    o;
        logic [64:0] s;
        logic [64:0] sv;
        logic        known;
        logic        v;
        o = '0; s = '0; sv = '0; known = 1'b1; v = 1'b0;
        case (c)
            ALU_AND:  s = {1'b0, a & b};
            ALU_OR:   s = {1'b0, a | b};
            ALU_PASS: s = {1'b0, b};
            ALU_ADD, ALU_ADDS: begin
                s  = {1'b0, a} + {1'b0, b};
                sv = $signed({a[63], a}) + $signed({b[63], b});
                v  = sv[64] != sv[63];
            end
            ALU_SUB, ALU_SUBS: begin
                s  = {1'b0, a} + {1'b0, ~b} + 65'd1;
                sv = $signed({a[63], a}) - $signed({b[63], b});
                v  = sv[64] != sv[63];
            end
            default: known = 1'b0;
        endcase
        o.result = s[63:0];
        o.zero   = (s[63:0] == 64'd0);
        o.flags  = {o.zero, s[63], s[64], v};
        o.wf     = known && c[SETFLAGS_BIT];
        return o;
    endfunction

    assign alu_o    = alu_fn(alu_a, alu_b, alu_c);
    assign fp_alu_o = alu_fn(fp_alu_a, fp_alu_b, fp_alu_c);

    alu_arbiter #(.DATA_W(DW), .ALUC_W(CW), .FIXED_PRIO(1'b0)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_c           (alu_c),
        .alu_result      (alu_o.result),
        .alu_zero        (alu_o.zero),
        .alu_flags       (alu_o.flags),
        .alu_write_flags (alu_o.wf),
        .cpsr_wr_en      (cpsr_wr_en),
        .cpsr_wr_data    (cpsr_wr_data),
        .cpsr            (cpsr)
    );

    alu_arbiter #(.DATA_W(DW), .ALUC_W(CW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_fp),
        .alu_a           (fp_alu_a),
        .alu_b           (fp_alu_b),
        .alu_c           (fp_alu_c),
        .alu_result      (fp_alu_o.result),
        .alu_zero        (fp_alu_o.zero),
        .alu_flags       (fp_alu_o.flags),
        .alu_write_flags (fp_alu_o.wf),
        .cpsr_wr_en      (1'b0),
        .cpsr_wr_data    (4'h0),
        .cpsr            (fp_cpsr)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: response slot contents, NZCV and last winner.
    logic        m_valid = 1'b0;
    logic        m_id = 1'b0;
    logic [63:0] m_result = '0;
    logic        m_zero = 1'b0;
    logic        m_fw = 1'b0;
    logic [3:0]  m_cpsr = '0;
    logic        m_last = 1'b1;
    logic [1:0]  last_acc = '0;
    logic [4:0]  ops [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] c);
        bus.req_valid[i]          = v;
        bus.req_a[i*DW +: DW]     = a;
        bus.req_b[i*DW +: DW]     = b;
        bus.req_aluc[i*CW +: CW]  = c;
    endtask

    task automatic chk_rsp();
        chk("rsp_valid", bus.rsp_valid, m_valid);
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_result", bus.rsp_result, m_result);
        chk("rsp_zero", bus.rsp_zero, m_zero);
        chk("rsp_flags_wr", bus.rsp_flags_wr, m_fw);
        chk("cpsr", cpsr, m_cpsr);
    endtask

    // One clock of the main DUT with inputs already applied.
    task automatic cycle();
        logic        any, free;
        int          w;
        logic [1:0]  er;
        logic [63:0] pa, pb;
        logic [4:0]  pc;
        alu_out_t    o;
        #1;
        any  = |bus.req_valid;
        free = !m_valid || bus.rsp_ready;
        // On a tie the requester that did not win last time goes first.
        if (&bus.req_valid) w = (m_last == 1'b0) ? 1 : 0;
        else                w = bus.req_valid[1] ? 1 : 0;
        er = (any && free) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
        pa = any ? bus.req_a[w*DW +: DW] : 64'd0;
        pb = any ? bus.req_b[w*DW +: DW] : 64'd0;
        pc = any ? bus.req_aluc[w*CW +: CW] : ALU_AND;
        chk("req_ready", bus.req_ready, er);
        chk("alu_a", alu_a, pa);
        chk("alu_b", alu_b, pb);
        chk("alu_c", alu_c, pc);
        last_acc = er;
        if (er != 2'b00) begin
            o        = alu_fn(pa, pb, pc);
            m_valid  = 1'b1;
            m_id     = (w == 1);
            m_result = o.result;
            m_zero   = o.zero;
            m_fw     = o.wf;
            m_last   = (w == 1);
            if (o.wf)            m_cpsr = o.flags;
            else if (cpsr_wr_en) m_cpsr = cpsr_wr_data;
        end else begin
            if (bus.rsp_ready) m_valid = 1'b0;
            if (cpsr_wr_en)    m_cpsr  = cpsr_wr_data;
        end
        @(posedge clk);
        #1;
        chk_rsp();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready, 2'b00);
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_zero = 1'b0; m_fw = 1'b0;
        m_cpsr = 4'b0000; m_last = 1'b1;
        chk_rsp();
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] held;
        ops[0] = ALU_AND;  ops[1] = ALU_OR;   ops[2] = ALU_ADD;  ops[3] = ALU_ADDS;
        ops[4] = ALU_SUB;  ops[5] = ALU_SUBS; ops[6] = ALU_PASS; ops[7] = 5'b01111;

        reset = 1'b1;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_aluc = '0;
        bus.rsp_ready = 1'b1;
        bus_fp.req_valid = '0; bus_fp.req_a = '0; bus_fp.req_b = '0; bus_fp.req_aluc = '0;
        bus_fp.rsp_ready = 1'b1;
        cpsr_wr_en = 1'b0; cpsr_wr_data = '0;
        do_reset();

        // ADD 5+7 from requester 0.
        set_req(0, 1'b1, 64'd5, 64'd7, ALU_ADD);
        cycle();
        chk("add_result", bus.rsp_result, 64'd12);
        set_req(0, 1'b0, '0, '0, ALU_AND);

        // SUBS 3-3 from requester 1 sets Z and C.
        set_req(1, 1'b1, 64'd3, 64'd3, ALU_SUBS);
        cycle();
        chk("subs_cpsr", cpsr, 4'b1010);
        set_req(1, 1'b0, '0, '0, ALU_AND);

        // Both requesters busy: grants alternate; fixed-priority copy favours 0.
        set_req(0, 1'b1, 64'd100, 64'd1, ALU_ADD);
        set_req(1, 1'b1, 64'hF0, 64'h0F, ALU_OR);
        bus_fp.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fp_req_ready", bus_fp.req_ready, 2'b01);
            cycle();
            chk("rr_alternate", last_acc, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("fp_rsp_id", bus_fp.rsp_id, 1'b0);
        end
        bus_fp.req_valid = 2'b00;
        set_req(1, 1'b0, '0, '0, ALU_AND);

        // Stall three cycles, then drain and accept together.
        set_req(0, 1'b1, 64'd9, 64'd4, ALU_SUB);
        bus.rsp_ready = 1'b0;
        held = bus.rsp_result;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_hold", bus.rsp_result, held);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        chk("drain_accept", last_acc, 2'b01);
        set_req(0, 1'b0, '0, '0, ALU_AND);

        // External restore alone, then colliding with a flag-setting op.
        cpsr_wr_en = 1'b1; cpsr_wr_data = 4'b0011;
        cycle();
        cpsr_wr_data = 4'b0000;
        set_req(0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADDS);
        cycle();
        chk("adds_ovf_cpsr", cpsr, 4'b0101);
        cpsr_wr_en = 1'b0;
        set_req(0, 1'b0, '0, '0, ALU_AND);

        // Reset with a held response and a pending request.
        set_req(1, 1'b1, 64'd1, 64'd2, ALU_ADD);
        bus.rsp_ready = 1'b0;
        cycle();
        set_req(1, 1'b0, '0, '0, ALU_AND);
        set_req(0, 1'b1, 64'd6, 64'd6, ALU_SUBS);
        cycle();
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(1, 1'b1, 64'd8, 64'd8, ALU_AND);
        cycle();
        chk("post_rst_pref", last_acc, 2'b01);

        // Randomized traffic; a pending request is held until accepted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i] || last_acc[i]) begin
                    if ($urandom_range(1) == 1)
                        set_req(i, ($urandom_range(3) != 0),
                                64'($urandom_range(3)), 64'($urandom_range(3)),
                                ops[$urandom_range(7)]);
                    else
                        set_req(i, ($urandom_range(3) != 0),
                                {$urandom, $urandom}, {$urandom, $urandom},
                                ops[$urandom_range(7)]);
                end
            end
            bus.rsp_ready = ($urandom_range(9) < 7);
            cpsr_wr_en    = ($urandom_range(4) == 0);
            cpsr_wr_data  = 4'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 64-bit ALU between two requesters: requester 0 is the pipeline execute stage, requester 1 is the address/auxiliary unit.
- Arbitrates each cycle, drives the ALU operand and control inputs with the winner's payload, and registers the result into a response slot that has backpressure.
- Owns the architectural NZCV (CPSR) register and updates it whenever the granted operation asserts write_flags.
- Sits between the requesters and the alu instance in the datapath.

Parameters:
- DATA_W, 64, operand/result width.
- ALUC_W, 5, ALU control code width (bit 4 = set-flags).
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept
- req_a  in  2*DATA_W  operand a; requester i in slice [i*DATA_W +: DATA_W]
- req_b  in  2*DATA_W  operand b, same packing
- req_aluc  in  2*ALUC_W  ALU control code, same packing
- alu_a, alu_b  out  DATA_W  to ALU
- alu_c  out  ALUC_W  to ALU
- alu_result  in  DATA_W  from ALU
- alu_zero  in  1  from ALU
- alu_flags  in  4  from ALU: [3]=Z, [2]=N, [1]=C, [0]=V
- alu_write_flags  in  1  from ALU
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index of the response
- rsp_result  out  DATA_W  registered result
- rsp_zero  out  1  registered zero
- rsp_flags_wr  out  1  the operation updated CPSR
- cpsr_wr_en  in  1  external CPSR write (flag restore)
- cpsr_wr_data  in  4  external CPSR value
- cpsr  out  4  NZCV register, same bit order as alu_flags

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_flags_wr=0, cpsr=0, rr_ptr=0 (requester 0 preferred). Reset drops any pending response.
- slot_free = !rsp_valid || rsp_ready.
- Grant is combinational:
  - Candidates are the requesters with req_valid=1.
  - With one candidate, it wins.
  - With two, rr_ptr wins; with FIXED_PRIO=1, requester 0 wins.
- req_ready[i] = slot_free && (grant == i). At most one ready bit is high per cycle. req_ready may depend combinationally on the other requester's req_valid.
- Requesters hold valid and payload stable until accepted; retraction is not supported. Verification asserts this.
- ALU drive:
  - Granted payload goes to alu_a/alu_b/alu_c combinationally, whether or not slot_free.
  - With no valid requester, drive 0/0/5'b00000 (AND, no flag write).
- Accept = req_valid[g] && req_ready[g]. At the clock edge after an accept:
  - rsp_valid <= 1.
  - rsp_id <= g, rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_flags_wr <= alu_write_flags.
- The response is held stable while rsp_valid && !rsp_ready. During that stall no requester is accepted.
- rsp_valid clears on rsp_ready when no new accept occurs in that cycle. Accept and drain in the same cycle is legal, giving one op per cycle throughput and a latency of 1 cycle.
- CPSR:
  - On an accept with alu_write_flags=1, cpsr <= alu_flags at the same edge the response is captured.
  - Else if cpsr_wr_en=1, cpsr <= cpsr_wr_data.
  - When both occur in one cycle, the ALU write wins and the external write is lost.
- rr_ptr updates only on accept: rr_ptr <= ~g. It is not updated in FIXED_PRIO mode.
- Unknown ALU codes are passed through unchanged; the ALU returns 0. No error is raised.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUc constants: AND=00000, OR=00001, ADD=00010, ADDS=10010, SUB=00110, SUBS=10110, PASS=00111.
  - SETFLAGS_BIT=4.
  - Flag indices: FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - DATA_W default.
- Sub-module rr_arbiter2 contains the two-way grant logic and rr_ptr register, with a fixed-priority option.
- The alu itself is instantiated outside this block.

Test Plan:
- Reset, then req0 sends ADD a=5 b=7 with rsp_ready=1 -> req_ready[0]=1 in that cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0, cpsr=0000.
- req1 sends SUBS a=3 b=3 -> rsp_result=0, rsp_zero=1, rsp_flags_wr=1. cpsr[3]=1 (Z) and cpsr[1]=1 (C, no borrow).
- Both requesters hold valid for 4 cycles with rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id follows. With FIXED_PRIO=1, all four grants go to requester 0.
- Response held with rsp_ready=0 for 3 cycles -> req_ready=00, rsp fields stable. On rsp_ready=1 the held response drains and the next request is accepted in the same cycle.
- ADDS a=0x7FFF_FFFF_FFFF_FFFF b=1 accepted in the same cycle as cpsr_wr_en=1, cpsr_wr_data=0000 -> cpsr=0101 (N, V), so the ALU write wins.
- Reset asserted while rsp_valid=1 and a request is pending -> next cycle rsp_valid=0, cpsr=0000, req_ready=00 during reset, and requester 0 is preferred afterwards.
